fir_decimate: RTL

Downstream stage of the `fir` block: consumes the filtered sample stream (`outP`/`out_enable` of the filter) and decimates it by R with accumulate-and-dump. Each dump is rounded, scaled and saturated back to BITWIDTH. Results are buffered in a small FIFO and presented on a valid/ready interface, so a stalling consumer never stalls the filter. Overflowing results are dropped and flagged.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/fir_decimate.sv | 100 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared helpers for the fir family: ceiling log2 and signed saturation bounds.
package fir_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with read/write pointers and an occupancy count register.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [clog2(DEPTH):0]    count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});

endmodule

// File: rtl/fir_decimate.sv
// Accumulate-and-dump decimator by R with round/shift/saturate and a buffered valid/ready output.
module fir_decimate
  import fir_pkg::*;
#(
  parameter int BITWIDTH = 16,
  parameter int R        = 4,
  parameter int SHIFT    = 2,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_enable,
  input  logic signed [BITWIDTH-1:0] inP,
  output logic signed [BITWIDTH-1:0] outP,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow
);

  localparam int LR   = clog2(R);
  localparam int ACCW = BITWIDTH + LR;
  localparam int EW   = ACCW + 1;
  localparam int PW   = (LR > 0) ? LR : 1;
  localparam int CW   = clog2(DEPTH) + 1;

  localparam logic signed [EW-1:0] SAT_HI = EW'(sat_max(BITWIDTH));
  localparam logic signed [EW-1:0] SAT_LO = EW'(sat_min(BITWIDTH));
  localparam logic signed [EW-1:0] RND    = EW'((64'd1 << SHIFT) >> 1);

  logic        [PW-1:0]       phase;
  logic signed [ACCW-1:0]     acc;
  logic signed [EW-1:0]       sum_ext;
  logic signed [EW-1:0]       rounded;
  logic signed [EW-1:0]       shifted;
  logic signed [BITWIDTH-1:0] result;
  logic                       dump;
  logic                       pop;
  logic                       drop;
  logic [BITWIDTH-1:0]        fifo_head;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;

  // One spare bit above the accumulator keeps the rounding add from wrapping.
  always_comb begin
    sum_ext = EW'(acc) + EW'(inP);
    rounded = sum_ext + RND;
    shifted = rounded >>> SHIFT;
    if (shifted > SAT_HI) begin
      result = SAT_HI[BITWIDTH-1:0];
    end else if (shifted < SAT_LO) begin
      result = SAT_LO[BITWIDTH-1:0];
    end else begin
      result = shifted[BITWIDTH-1:0];
    end
  end

  assign dump      = in_enable && (phase == PW'(R - 1));
  assign out_valid = (fifo_count != {CW{1'b0}});
  assign pop       = out_ready && !fifo_empty;
  assign drop      = dump && fifo_full && !pop;
  assign outP      = out_valid ? $signed(fifo_head) : {BITWIDTH{1'b0}};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase    <= {PW{1'b0}};
      acc      <= {ACCW{1'b0}};
      overflow <= 1'b0;
    end else begin
      if (in_enable) begin
        if (dump) begin
          phase <= {PW{1'b0}};
          acc   <= {ACCW{1'b0}};
        end else begin
          phase <= phase + PW'(1);
          acc   <= acc + ACCW'(inP);
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (BITWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (dump),
    .push_data (result),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
